// File: rtl/fdiv_mantissa_division_pkg.sv
// Shared FDIV package: state encoding and width helpers for the mantissa divider.
package fdiv_mantissa_division_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } fdiv_state_e;

    function automatic int op_w(input int m);
        return m + 2;
    endfunction

    function automatic int quo_w(input int m);
        return m + 3;
    endfunction

    function automatic int cnt_w(input int m);
        return $clog2(m + 3);
    endfunction

endpackage

// File: rtl/fdiv_restoring_step.sv
// One radix-2 restoring division step: compare, conditional subtract, shift.
module fdiv_restoring_step
    import fdiv_mantissa_division_pkg::*;
#(
    parameter int man = 22
) (
    input  logic [quo_w(man)-1:0] rem,
    input  logic [op_w(man)-1:0]  div,
    output logic                  q,
    output logic [quo_w(man)-1:0] rem_next
);

    localparam int QW = quo_w(man);

    logic [QW-1:0] div_ext;
    logic [QW-1:0] diff;
    logic [QW-1:0] kept;

    assign div_ext  = {1'b0, div};
    assign q        = (rem >= div_ext);
    assign diff     = rem - div_ext;
    assign kept     = q ? diff : rem;
    assign rem_next = kept << 1;

endmodule

// File: rtl/fdiv_mantissa_division.sv
// Sequential radix-2 restoring mantissa divider, one quotient bit per clock.
// FDIV_EARLY_TERMINATION_EN: stop as soon as the partial remainder reaches zero.
module fdiv_mantissa_division
    import fdiv_mantissa_division_pkg::*;
#(
    parameter int man = 22,
    parameter int exp = 7
) (
    input  logic                  clk,
    input  logic                  rst_l,
    input  logic [man+1:0]        Mantissa_Division_input_A,
    input  logic [man+1:0]        Mantissa_Division_input_B,
    input  logic                  Mantissa_Division_input_Start,
    output logic                  Mantissa_Division_output_Busy,
    output logic                  Mantissa_Division_output_Valid,
    output logic [man+2:0]        Mantissa_Division_output_Quotient,
    output logic                  Mantissa_Division_output_Sticky,
    output logic                  Mantissa_Division_output_Div_By_Zero
);

    localparam int OW = op_w(man);
    localparam int QW = quo_w(man);
    localparam int CW = cnt_w(man);
    localparam logic [CW-1:0] CNT_INIT = CW'(man + 2);
    localparam int UNUSED_EXP_W = exp + 1;

    fdiv_state_e state_q;
    fdiv_state_e state_d;

    logic [OW-1:0] div_q;
    logic [QW-1:0] rem_q;
    logic [QW-1:0] rem_next;
    logic [QW-1:0] quo_q;
    logic [QW-1:0] quo_shift;
    logic [CW-1:0] cnt_q;
    logic          q_bit;
    logic          valid_q;
    logic          sticky_q;
    logic          dbz_q;
    logic          accept;
    logic          div0;
    logic          last;

    fdiv_restoring_step #(
        .man(man)
    ) u_step (
        .rem     (rem_q),
        .div     (div_q),
        .q       (q_bit),
        .rem_next(rem_next)
    );

    assign div0      = (Mantissa_Division_input_B == '0);
    assign accept    = (state_q == IDLE) && Mantissa_Division_input_Start;
    assign quo_shift = {quo_q[QW-2:0], q_bit};

`ifdef FDIV_EARLY_TERMINATION_EN
    assign last = (cnt_q == '0) || (rem_next == '0);
`else
    assign last = (cnt_q == '0);
`endif

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (Mantissa_Division_input_Start && !div0) state_d = BUSY;
            BUSY: if (last) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            div_q    <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            cnt_q    <= '0;
            valid_q  <= 1'b0;
            sticky_q <= 1'b0;
            dbz_q    <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            if (accept) begin
                if (div0) begin
                    valid_q  <= 1'b1;
                    quo_q    <= '1;
                    sticky_q <= 1'b0;
                    dbz_q    <= 1'b1;
                end else begin
                    div_q <= Mantissa_Division_input_B;
                    rem_q <= {1'b0, Mantissa_Division_input_A};
                    quo_q <= '0;
                    cnt_q <= CNT_INIT;
                    dbz_q <= 1'b0;
                end
            end else if (state_q == BUSY) begin
                rem_q <= rem_next;
                cnt_q <= cnt_q - CW'(1);
                if (last) begin
                    // Left-align: skipped low quotient bits are zero-filled.
                    quo_q    <= quo_shift << cnt_q;
                    sticky_q <= (rem_next != '0);
                    valid_q  <= 1'b1;
                end else begin
                    quo_q <= quo_shift;
                end
            end
        end
    end

    assign Mantissa_Division_output_Busy        = (state_q == BUSY);
    assign Mantissa_Division_output_Valid       = valid_q;
    assign Mantissa_Division_output_Quotient    = quo_q;
    assign Mantissa_Division_output_Sticky      = sticky_q;
    assign Mantissa_Division_output_Div_By_Zero = dbz_q;

endmodule

// File: tb/tb_fdiv_mantissa_division.sv
// Self-checking bench for fdiv_mantissa_division with a result scoreboard.
module tb_fdiv_mantissa_division;

    typedef struct {
        logic [24:0] quo;
        logic        sticky;
        logic        dbz;
        int          lat;
    } exp_t;

    logic        clk;
    logic        rst_l;
    logic [23:0] a;
    logic [23:0] b;
    logic        start;
    logic        busy;
    logic        valid;
    logic [24:0] quo;
    logic        sticky;
    logic        dbz;

    exp_t sb[$];
    int   checks;
    int   errors;

    fdiv_mantissa_division #(
        .man(22),
        .exp(7)
    ) dut (
        .clk                                 (clk),
        .rst_l                               (rst_l),
        .Mantissa_Division_input_A           (a),
        .Mantissa_Division_input_B           (b),
        .Mantissa_Division_input_Start       (start),
        .Mantissa_Division_output_Busy       (busy),
        .Mantissa_Division_output_Valid      (valid),
        .Mantissa_Division_output_Quotient   (quo),
        .Mantissa_Division_output_Sticky     (sticky),
        .Mantissa_Division_output_Div_By_Zero(dbz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Reference: long division by 64-bit arithmetic, then drive one Start.
    task automatic issue(input logic [23:0] av, input logic [23:0] bv);
        exp_t        e;
        logic [63:0] num;
        logic [63:0] qv;
        logic [63:0] rv;
        num = {40'd0, av} << 24;
        if (bv == 24'd0) begin
            e.quo    = 25'h1FFFFFF;
            e.sticky = 1'b0;
            e.dbz    = 1'b1;
            e.lat    = 0;
        end else begin
            qv       = num / {40'd0, bv};
            rv       = num % {40'd0, bv};
            e.quo    = qv[24:0];
            e.sticky = (rv != 64'd0);
            e.dbz    = 1'b0;
            e.lat    = 25;
`ifdef FDIV_EARLY_TERMINATION_EN
            if (rv == 64'd0) begin
                int tz;
                tz = 0;
                while (tz < 25 && !qv[tz]) tz++;
                e.lat = 25 - tz;
            end
`endif
        end
        sb.push_back(e);
        a     = av;
        b     = bv;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_valid(input string tag, input int skip);
        exp_t e;
        int   n;
        n = 0;
        while (valid !== 1'b1 && n < 64) begin
            @(negedge clk);
            n++;
        end
        chk({tag, " valid"}, valid, 1);
        chk({tag, " sb"}, sb.size() > 0, 1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({tag, " lat"}, n, e.lat - skip);
            chk({tag, " quo"}, quo, e.quo);
            chk({tag, " sticky"}, sticky, e.sticky);
            chk({tag, " dbz"}, dbz, e.dbz);
        end
        chk({tag, " busy_low"}, busy, 0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_l  = 1'b0;
        start  = 1'b0;
        a      = '0;
        b      = '0;
        repeat (2) @(negedge clk);
        chk("rst busy", busy, 0);
        chk("rst valid", valid, 0);
        chk("rst quo", quo, 0);
        chk("rst sticky", sticky, 0);
        chk("rst dbz", dbz, 0);
        rst_l = 1'b1;
        @(negedge clk);

        issue(24'h800000, 24'h800000);
        chk("eq busy", busy, 1);
        wait_valid("eq", 0);
        @(negedge clk);
        chk("eq pulse", valid, 0);
        chk("eq hold", quo, 25'h1000000);

        issue(24'hC00000, 24'h800000);
        wait_valid("1.5", 0);

        issue(24'h800000, 24'hC00000);
        wait_valid("0.667", 0);

        // Divide by zero issued in the Valid cycle of the previous result.
        issue(24'h900000, 24'h000000);
        chk("dbz busy", busy, 0);
        wait_valid("dbz", 0);
        @(negedge clk);
        chk("dbz busy2", busy, 0);

        issue(24'hA00000, 24'h900000);
        repeat (4) @(negedge clk);
        a     = 24'hF00000;
        b     = 24'h800001;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("ign busy", busy, 1);
        wait_valid("ign", 5);

        issue(24'hFFFFFF, 24'h800000);
        wait_valid("b2b1", 0);
        issue(24'h800000, 24'hFFFFFF);
        wait_valid("b2b2", 0);

        for (int i = 0; i < 3; i++) begin
            issue(24'h800000 | 24'($urandom), 24'h800000 | 24'($urandom));
            wait_valid("rand", 0);
        end

        issue(24'hB00000, 24'hD00000);
        repeat (9) @(negedge clk);
        #2 rst_l = 1'b0;
        #1;
        chk("abort busy", busy, 0);
        chk("abort valid", valid, 0);
        chk("abort quo", quo, 0);
        chk("abort sticky", sticky, 0);
        chk("abort dbz", dbz, 0);
        void'(sb.pop_front());
        repeat (3) @(negedge clk);
        chk("abort novalid", valid, 0);
        rst_l = 1'b1;
        @(negedge clk);
        issue(24'hB00000, 24'hD00000);
        wait_valid("post_rst", 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
